// File: rtl/weight_accum_pkg.sv
// Shared defaults and helpers for the multi-lane weight accumulator.
// Saturation bounds are only consumed when ACCUM_SAT_EN is defined.
package weight_accum_pkg;

  localparam int DEF_LANES  = 16;
  localparam int DEF_IN_W   = 8;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_SIGNED = 1;

  // Bounds are returned 64 bits wide; callers truncate to their accumulator width.
  function automatic logic [63:0] sat_max(int acc_w, int is_signed);
    if (is_signed != 0) return (64'd1 << (acc_w - 1)) - 64'd1;
    if (acc_w >= 64) return {64{1'b1}};
    return (64'd1 << acc_w) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(int acc_w, int is_signed);
    if (is_signed != 0) return {64{1'b1}} << (acc_w - 1);
    return 64'd0;
  endfunction

  function automatic int lane_lsb(int lane, int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/weight_accum_array_if.sv
// Input-beat and result handshake bundle for weight_accum_array.
// out_ovf exists only when ACCUM_SAT_EN is defined.
interface weight_accum_array_if
  import weight_accum_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic                   clear;
  logic [CNT_W-1:0]       cfg_len;
  logic [LANES-1:0]       lane_mask;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*IN_W-1:0]  in_val;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*ACC_W-1:0] out_sum;
  logic [CNT_W-1:0]       out_last_len;
`ifdef ACCUM_SAT_EN
  logic [LANES-1:0]       out_ovf;
`endif

  modport master (
    output clear, cfg_len, lane_mask, in_valid, in_val, out_ready,
    input  in_ready, out_valid, out_sum, out_last_len
`ifdef ACCUM_SAT_EN
    , input out_ovf
`endif
  );

  modport slave (
    input  clear, cfg_len, lane_mask, in_valid, in_val, out_ready,
    output in_ready, out_valid, out_sum, out_last_len
`ifdef ACCUM_SAT_EN
    , output out_ovf
`endif
  );
endinterface

// File: rtl/weight_accum_array_accum_lane.sv
// One accumulation lane: extend, add, optional saturate (ACCUM_SAT_EN), mask and clear.
// sum_next is the value including the current beat, so the top can capture a finished block.
module accum_lane
  import weight_accum_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int SIGNED = DEF_SIGNED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             accept,
  input  logic             last,
  input  logic             en,
  input  logic [IN_W-1:0]  din,
`ifdef ACCUM_SAT_EN
  output logic             ovf_next,
`endif
  output logic [ACC_W-1:0] sum_next
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] added;

  assign ext = (SIGNED != 0) ? ACC_W'($signed(din)) : ACC_W'(din);

`ifdef ACCUM_SAT_EN
  localparam logic [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W, SIGNED));
  localparam logic [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W, SIGNED));

  logic [ACC_W:0] wide;
  logic           ovf_add;
  logic           ovf_q;

  // One guard bit exposes overflow; in signed mode its sign says which rail to clamp to.
  always_comb begin
    wide = {(SIGNED != 0) ? acc[ACC_W-1] : 1'b0, acc}
         + {(SIGNED != 0) ? ext[ACC_W-1] : 1'b0, ext};
    if (SIGNED != 0) begin
      ovf_add = wide[ACC_W] ^ wide[ACC_W-1];
      added   = ovf_add ? (wide[ACC_W] ? MIN_V : MAX_V) : wide[ACC_W-1:0];
    end else begin
      ovf_add = wide[ACC_W];
      added   = ovf_add ? MAX_V : wide[ACC_W-1:0];
    end
  end

  assign ovf_next = ovf_q | (en & ovf_add);

  always_ff @(posedge clk) begin
    if (rst || clear) ovf_q <= 1'b0;
    else if (accept)  ovf_q <= last ? 1'b0 : ovf_next;
  end
`else
  assign added = acc + ext;
`endif

  assign sum_next = en ? added : acc;

  always_ff @(posedge clk) begin
    if (rst || clear) acc <= '0;
    else if (accept)  acc <= last ? '0 : sum_next;
  end

endmodule

// File: rtl/weight_accum_array.sv
// Double-buffered multi-lane weight accumulator: block counting, length latch and result buffer.
// Optional saturating arithmetic and out_ovf under ACCUM_SAT_EN.
module weight_accum_array
  import weight_accum_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int IN_W   = DEF_IN_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int SIGNED = DEF_SIGNED
) (
  input logic                 clk,
  input logic                 rst,
  weight_accum_array_if.slave bus
);

  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       len_q;
  logic [CNT_W-1:0]       eff_len;
  logic [CNT_W-1:0]       last_len_q;
  logic                   last;
  logic                   accept;
  logic                   out_valid_q;
  logic [LANES*ACC_W-1:0] sum_next;
  logic [LANES*ACC_W-1:0] out_sum_q;
`ifdef ACCUM_SAT_EN
  logic [LANES-1:0]       ovf_next;
  logic [LANES-1:0]       out_ovf_q;
`endif

  // The first beat of a block uses cfg_len directly since the latch is only loaded on that beat.
  always_comb begin
    eff_len = len_q;
    if (count == '0) eff_len = (bus.cfg_len == '0) ? CNT_W'(1) : bus.cfg_len;
  end

  assign last         = (count == eff_len - CNT_W'(1));
  assign bus.in_ready = !rst && !(out_valid_q && !bus.out_ready && last);
  assign accept       = bus.in_valid && bus.in_ready && !bus.clear;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    accum_lane #(
      .IN_W   (IN_W),
      .ACC_W  (ACC_W),
      .SIGNED (SIGNED)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clear    (bus.clear),
      .accept   (accept),
      .last     (last),
      .en       (bus.lane_mask[i]),
      .din      (bus.in_val[lane_lsb(i, IN_W) +: IN_W]),
`ifdef ACCUM_SAT_EN
      .ovf_next (ovf_next[i]),
`endif
      .sum_next (sum_next[lane_lsb(i, ACC_W) +: ACC_W])
    );
  end

  // A completing block wins over a drain in the same cycle so the buffer reloads without a gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      len_q       <= CNT_W'(1);
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      last_len_q  <= '0;
`ifdef ACCUM_SAT_EN
      out_ovf_q   <= '0;
`endif
    end else begin
      if (bus.clear) begin
        count <= '0;
      end else if (accept) begin
        count <= last ? '0 : count + CNT_W'(1);
        if (count == '0) len_q <= eff_len;
      end
      if (accept && last) begin
        out_valid_q <= 1'b1;
        out_sum_q   <= sum_next;
        last_len_q  <= eff_len;
`ifdef ACCUM_SAT_EN
        out_ovf_q   <= ovf_next;
`endif
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_sum      = out_sum_q;
  assign bus.out_last_len = last_len_q;
`ifdef ACCUM_SAT_EN
  assign bus.out_ovf      = out_ovf_q;
`endif

endmodule

// File: tb/tb_weight_accum_array.sv
// Self-checking bench for weight_accum_array: table-driven blocks on an unsigned 4-lane,
// 10-bit instance plus hand sequences for backpressure, clear, reset and a signed instance.
module tb_weight_accum_array;
  import weight_accum_pkg::*;

  localparam int LANES  = 4;
  localparam int IN_W   = 8;
  localparam int ACC_W  = 10;
  localparam int SACC_W = 12;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  weight_accum_array_if #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W),  .CNT_W(CNT_W)) bu ();
  weight_accum_array_if #(.LANES(LANES), .IN_W(IN_W), .ACC_W(SACC_W), .CNT_W(CNT_W)) bs ();

  weight_accum_array #(
    .LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SIGNED(0)
  ) dut_u (.clk(clk), .rst(rst), .bus(bu.slave));

  weight_accum_array #(
    .LANES(LANES), .IN_W(IN_W), .ACC_W(SACC_W), .CNT_W(CNT_W), .SIGNED(1)
  ) dut_s (.clk(clk), .rst(rst), .bus(bs.slave));

  typedef struct packed {
    logic [LANES*ACC_W-1:0] sum;
    logic [CNT_W-1:0]       len;
    logic [LANES-1:0]       ovf;
  } exp_t;

  typedef struct packed {
    logic [7:0]                  len;
    logic [7:0]                  nb;
    logic [4:0][7:0]             v;
    logic [7:0]                  step;
    logic [3:0]                  mask;
    logic [LANES-1:0][ACC_W-1:0] exp_sum;
    logic [3:0]                  exp_ovf;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[6];
  int   checks = 0;
  int   passed = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drives one beat (lane i carries v - i*step) and waits until it is accepted.
  task automatic applyStimulus(input logic [7:0] v, input logic [7:0] step, input logic [3:0] mask);
    bit ok;
    @(posedge clk); #1;
    bu.in_valid  = 1'b1;
    bu.lane_mask = mask;
    for (int i = 0; i < LANES; i++) bu.in_val[i*IN_W +: IN_W] = 8'(int'(v) - i * int'(step));
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = bu.in_ready;
      @(posedge clk); #1;
    end
    bu.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      $display("[TB] FAIL in_ready_timeout: got in_ready=0 for 50 cycles, expected 1");
    end
  endtask

  task automatic pushExp(input logic [LANES*ACC_W-1:0] sum, input logic [CNT_W-1:0] len,
                         input logic [LANES-1:0] ovf);
    exp_t e;
    e.sum = sum;
    e.len = len;
    e.ovf = ovf;
    sbq.push_back(e);
  endtask

  // Every completed handshake on the unsigned instance is checked against the queue head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bu.out_valid && bu.out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_result: got sum 0x%0h, expected no result", bu.out_sum);
      end else begin
        e = sbq.pop_front();
        checkOutput("out_sum", 64'(bu.out_sum), 64'(e.sum));
        checkOutput("out_last_len", 64'(bu.out_last_len), 64'(e.len));
`ifdef ACCUM_SAT_EN
        checkOutput("out_ovf", 64'(bu.out_ovf), 64'(e.ovf));
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0] = '{len: 8'd3, nb: 8'd3, v: {8'd0, 8'd0, 8'd30, 8'd20, 8'd10}, step: 8'd0, mask: 4'hF,
               exp_sum: {4{10'd60}}, exp_ovf: 4'h0};
    tbl[1] = '{len: 8'd2, nb: 8'd2, v: {8'd0, 8'd0, 8'd0, 8'd200, 8'd100}, step: 8'd1, mask: 4'b0101,
               exp_sum: {10'd0, 10'd296, 10'd0, 10'd300}, exp_ovf: 4'h0};
`ifdef ACCUM_SAT_EN
    tbl[2] = '{len: 8'd5, nb: 8'd5, v: {5{8'd255}}, step: 8'd0, mask: 4'hF,
               exp_sum: {4{10'd1023}}, exp_ovf: 4'hF};
`else
    tbl[2] = '{len: 8'd5, nb: 8'd5, v: {5{8'd255}}, step: 8'd0, mask: 4'hF,
               exp_sum: {4{10'd251}}, exp_ovf: 4'h0};
`endif
    tbl[3] = '{len: 8'd0, nb: 8'd1, v: {8'd0, 8'd0, 8'd0, 8'd0, 8'd7}, step: 8'd2, mask: 4'hF,
               exp_sum: {10'd1, 10'd3, 10'd5, 10'd7}, exp_ovf: 4'h0};
    tbl[4] = '{len: 8'd4, nb: 8'd4, v: {8'd0, 8'd80, 8'd70, 8'd60, 8'd50}, step: 8'd10, mask: 4'b1110,
               exp_sum: {10'd140, 10'd180, 10'd220, 10'd0}, exp_ovf: 4'h0};
    tbl[5] = '{len: 8'd1, nb: 8'd1, v: {8'd0, 8'd0, 8'd0, 8'd0, 8'd9}, step: 8'd0, mask: 4'h0,
               exp_sum: {4{10'd0}}, exp_ovf: 4'h0};

    bu.clear = 1'b0; bu.cfg_len = '0; bu.lane_mask = '0; bu.in_valid = 1'b0;
    bu.in_val = '0;  bu.out_ready = 1'b1;
    bs.clear = 1'b0; bs.cfg_len = 8'd2; bs.lane_mask = 4'b0101; bs.in_valid = 1'b0;
    bs.in_val = '0;  bs.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("in_ready_in_reset", 64'(bu.in_ready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", 64'(bu.in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(bu.out_valid), 64'd0);
    checkOutput("reset_out_sum", 64'(bu.out_sum), 64'd0);
    checkOutput("reset_out_last_len", 64'(bu.out_last_len), 64'd0);

    // Table of complete blocks with the consumer always ready
    for (int r = 0; r < 6; r++) begin
      bu.cfg_len = tbl[r].len;
      pushExp(tbl[r].exp_sum, (tbl[r].len == 8'd0) ? 8'd1 : tbl[r].len, tbl[r].exp_ovf);
      for (int k = 0; k < int'(tbl[r].nb); k++) applyStimulus(tbl[r].v[k], tbl[r].step, tbl[r].mask);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_latency", r), 64'(bu.out_valid), 64'd1);
    end

    // Backpressure: final beat of the second block stalls until the buffer drains
    @(posedge clk); #1;
    bu.out_ready = 1'b0;
    bu.cfg_len   = 8'd2;
    pushExp({4{10'd2}}, 8'd2, 4'h0);
    pushExp({4{10'd2}}, 8'd2, 4'h0);
    repeat (3) applyStimulus(8'd1, 8'd0, 4'hF);
    bu.in_valid  = 1'b1;
    bu.in_val    = {4{8'd1}};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("bp_in_ready_stalled", 64'(bu.in_ready), 64'd0);
      checkOutput("bp_out_sum_held", 64'(bu.out_sum), 64'({4{10'd2}}));
    end
    @(posedge clk); #1 bu.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_in_ready_on_drain", 64'(bu.in_ready), 64'd1);
    @(posedge clk); #1 bu.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_reload_out_valid", 64'(bu.out_valid), 64'd1);

    // clear mid-block while an earlier result is still pending
    @(posedge clk); #1;
    bu.out_ready = 1'b0;
    bu.cfg_len   = 8'd1;
    pushExp({4{10'd9}}, 8'd1, 4'h0);
    applyStimulus(8'd9, 8'd0, 4'hF);
    bu.cfg_len = 8'd4;
    repeat (2) applyStimulus(8'd7, 8'd0, 4'hF);
    bu.clear = 1'b1; bu.in_valid = 1'b1; bu.in_val = {4{8'd7}};
    @(negedge clk);
    checkOutput("clr_out_valid", 64'(bu.out_valid), 64'd1);
    @(posedge clk); #1 bu.clear = 1'b0; bu.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("clr_pending_valid", 64'(bu.out_valid), 64'd1);
    checkOutput("clr_pending_sum", 64'(bu.out_sum), 64'({4{10'd9}}));
    @(posedge clk); #1 bu.out_ready = 1'b1;
    pushExp({4{10'd4}}, 8'd4, 4'h0);
    repeat (4) applyStimulus(8'd1, 8'd0, 4'hF);

    // Reset in the middle of a block with a pending result
    @(posedge clk); #1;
    bu.out_ready = 1'b0;
    bu.cfg_len   = 8'd1;
    applyStimulus(8'd5, 8'd0, 4'hF);
    bu.cfg_len = 8'd3;
    repeat (2) applyStimulus(8'd2, 8'd0, 4'hF);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_out_valid", 64'(bu.out_valid), 64'd0);
    checkOutput("rst_mid_out_sum", 64'(bu.out_sum), 64'd0);
    checkOutput("rst_mid_out_last_len", 64'(bu.out_last_len), 64'd0);
    @(posedge clk); #1 bu.out_ready = 1'b1;
    pushExp({4{10'd6}}, 8'd3, 4'h0);
    repeat (3) applyStimulus(8'd2, 8'd0, 4'hF);

    // Signed instance: -128 then 5 on lanes 0 and 2 only
    @(posedge clk); #1;
    bs.in_valid = 1'b1;
    bs.in_val   = {4{8'h80}};
    @(negedge clk);
    checkOutput("s_in_ready", 64'(bs.in_ready), 64'd1);
    @(posedge clk); #1 bs.in_val = {4{8'h05}};
    @(posedge clk); #1 bs.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("s_out_valid", 64'(bs.out_valid), 64'd1);
    checkOutput("s_out_sum", 64'(bs.out_sum), 64'({12'h000, 12'hF85, 12'h000, 12'hF85}));
    checkOutput("s_out_last_len", 64'(bs.out_last_len), 64'd2);
`ifdef ACCUM_SAT_EN
    checkOutput("s_out_ovf", 64'(bs.out_ovf), 64'd0);
`endif

    for (int t = 0; t < 100 && sbq.size() != 0; t++) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
